// File: rtl/btn_debounce_hold.sv
// btn_debounce_hold
//   Debounces an active-low push-button and classifies each press as short
//   or long.
//
//   Parameters
//     CLK_FREQ        system clock frequency in Hz (informational)
//     DEBOUNCE_CYCLES consecutive stable cycles needed to accept a level change
//     HOLD_CYCLES     debounced-press duration that qualifies as a long press
//
//   Ports
//     clk             system clock, rising edge
//     rst             asynchronous reset, active low
//     btn_raw         raw button pin, active low, asynchronous to clk
//     btn_level       debounced button state, 1 = pressed
//     btn_press       one-cycle pulse when a press is accepted
//     btn_release     one-cycle pulse when a release is accepted
//     btn_hold        high while a long press is in progress
//     btn_hold_pulse  one-cycle pulse when a press first qualifies as long
module btn_debounce_hold #(
  parameter int unsigned CLK_FREQ        = 50_000_000,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500_000,
  parameter logic [27:0] HOLD_CYCLES     = 28'd150_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_hold,
  output logic btn_hold_pulse
);

  localparam logic [19:0] DB_MAX   = DEBOUNCE_CYCLES - 20'd1;
  localparam logic [27:0] HOLD_MAX = HOLD_CYCLES - 28'd1;

  if (CLK_FREQ == 0 || DEBOUNCE_CYCLES == 20'd0 || HOLD_CYCLES == 28'd0) begin : g_bad_params
    $error("btn_debounce_hold: CLK_FREQ, DEBOUNCE_CYCLES and HOLD_CYCLES must be nonzero");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PRESSED = 2'b01,
    ST_HELD    = 2'b10
  } state_t;

  // 2-flop synchronizer; resets to the released (high) level.
  logic r_sync0;
  logic r_sync1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync0 <= 1'b1;
      r_sync1 <= 1'b1;
    end else begin
      r_sync0 <= btn_raw;
      r_sync1 <= r_sync0;
    end
  end

  // Debounce: r_stable holds the accepted raw-polarity level.
  logic        r_stable;
  logic [19:0] r_db_cnt;
  logic        r_level;
  logic        w_db_flip;
  logic        w_press_evt;
  logic        w_release_evt;

  assign w_db_flip     = (r_sync1 != r_stable) && (r_db_cnt == DB_MAX);
  assign w_press_evt   = w_db_flip &&  r_stable;
  assign w_release_evt = w_db_flip && !r_stable;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stable <= 1'b1;
      r_db_cnt <= '0;
      r_level  <= 1'b0;
    end else if (r_sync1 == r_stable) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_MAX) begin
      r_stable <= ~r_stable;
      r_db_cnt <= '0;
      // Level is the inverse of the new stable value, i.e. the old one.
      r_level  <= r_stable;
    end else begin
      r_db_cnt <= r_db_cnt + 20'd1;
    end
  end

  // Press classification FSM with registered outputs.
  state_t      r_state;
  state_t      w_state_nxt;
  logic [27:0] r_hold_cnt;
  logic [27:0] w_hold_cnt_nxt;
  logic        r_press;
  logic        r_release;
  logic        r_hold;
  logic        r_hold_pulse;
  logic        w_press_nxt;
  logic        w_release_nxt;
  logic        w_hold_nxt;
  logic        w_hold_pulse_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_hold_cnt   <= '0;
      r_press      <= 1'b0;
      r_release    <= 1'b0;
      r_hold       <= 1'b0;
      r_hold_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_hold_cnt   <= w_hold_cnt_nxt;
      r_press      <= w_press_nxt;
      r_release    <= w_release_nxt;
      r_hold       <= w_hold_nxt;
      r_hold_pulse <= w_hold_pulse_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_hold_cnt_nxt   = r_hold_cnt;
    w_press_nxt      = 1'b0;
    w_release_nxt    = 1'b0;
    w_hold_nxt       = 1'b0;
    w_hold_pulse_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_press_evt) begin
          w_state_nxt    = ST_PRESSED;
          w_hold_cnt_nxt = '0;
          w_press_nxt    = 1'b1;
        end
      end
      ST_PRESSED: begin
        // Release is checked first so it wins over long-press qualification.
        if (w_release_evt) begin
          w_state_nxt   = ST_IDLE;
          w_release_nxt = 1'b1;
        end else if (r_hold_cnt == HOLD_MAX) begin
          w_state_nxt      = ST_HELD;
          w_hold_pulse_nxt = 1'b1;
          w_hold_nxt       = 1'b1;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + 28'd1;
        end
      end
      ST_HELD: begin
        // Hold counter stays frozen at HOLD_MAX here.
        if (w_release_evt) begin
          w_state_nxt   = ST_IDLE;
          w_release_nxt = 1'b1;
        end else begin
          w_hold_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign btn_level      = r_level;
  assign btn_press      = r_press;
  assign btn_release    = r_release;
  assign btn_hold       = r_hold;
  assign btn_hold_pulse = r_hold_pulse;

endmodule

// File: doc/btn_debounce_hold.md
BTN_DEBOUNCE_HOLD -- requirements
Module: btn_debounce_hold

Interface
REQ-001 Parameter: CLK_FREQ, default 50_000_000; system clock frequency in Hz (documentation only).
REQ-002 Parameter: DEBOUNCE_CYCLES, default 20'd500_000; consecutive stable cycles needed to accept a level change (10 ms).
REQ-003 Parameter: HOLD_CYCLES, default 28'd150_000_000; debounced-press duration that qualifies as a long press (3 s).
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 btn_raw  input  1  raw push-button pin, active-low (0 = pressed), asynchronous to clk.
REQ-007 btn_level  output  1  debounced button state, active-high (1 = pressed); feeds buzzer-request inputs.
REQ-008 btn_press  output  1  one-cycle pulse on accepted press.
REQ-009 btn_release  output  1  one-cycle pulse on accepted release.
REQ-010 btn_hold  output  1  level, high while a long press is in progress.
REQ-011 btn_hold_pulse  output  1  one-cycle pulse when a press first qualifies as long.

Function
REQ-012 btn_raw SHALL pass through a 2-flop synchronizer; no other logic SHALL sample btn_raw directly.
REQ-013 The debounce counter SHALL clear on every cycle the synchronized value equals the internal stable value.
REQ-014 The counter SHALL increment on every cycle the synchronized value differs from the stable value; it SHALL never exceed DEBOUNCE_CYCLES-1.
REQ-015 The stable value SHALL toggle, and the counter SHALL clear, on the edge where the counter equals DEBOUNCE_CYCLES-1 and the values still differ.
REQ-016 Total latency from a clean btn_raw change to btn_level change SHALL be 2+DEBOUNCE_CYCLES cycles.
REQ-017 Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no output change.
REQ-018 The FSM SHALL have states IDLE, PRESSED and HELD, encoded in 2 bits; the unused encoding SHALL return to IDLE.
REQ-019 IDLE->PRESSED SHALL occur on the stable press edge: btn_press=1 for that one cycle and the hold counter cleared.
REQ-020 In PRESSED, the hold counter SHALL increment each cycle.
REQ-021 PRESSED->HELD SHALL occur on the edge where the hold counter reaches HOLD_CYCLES-1: btn_hold_pulse=1 for one cycle, then btn_hold=1 until release.
REQ-022 PRESSED->IDLE or HELD->IDLE SHALL occur on the stable release edge: btn_release=1 for one cycle and btn_hold cleared on the same edge.
REQ-023 In HELD the hold counter SHALL freeze; it SHALL never wrap.
REQ-024 If release is accepted on the same edge the hold counter reaches HOLD_CYCLES-1, release SHALL win: no btn_hold_pulse, and the state goes to IDLE.
REQ-025 btn_press, btn_release and btn_hold_pulse SHALL be mutually exclusive in any cycle.
REQ-026 All outputs SHALL be registered; btn_level SHALL equal the inverted stable value.
REQ-027 Hold counter width SHALL be 28 bits and debounce counter width 20 bits; parameters beyond these ranges are unsupported.

Reset
REQ-028 With rst=0, asynchronously: synchronizer flops = 1 (released), stable value = 1, counters = 0, state = IDLE, and all outputs = 0.
REQ-029 Reset asserted mid-press SHALL drop all outputs to 0 immediately; after deassertion a still-held button SHALL re-qualify with full 2+DEBOUNCE_CYCLES latency and produce a fresh btn_press.
REQ-030 No output pulse SHALL be generated by reset deassertion itself.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10)
REQ-031 btn_raw 1->0 held -> btn_level=1 and btn_press=1 exactly 6 cycles later; btn_press low the next cycle.
REQ-032 btn_raw low for 3 cycles then high -> btn_level, btn_press and btn_release stay 0 throughout.
REQ-033 Press held 20 cycles after btn_press -> btn_hold_pulse 10 cycles after btn_press and btn_hold=1; on release, btn_release=1 and btn_hold=0 on the same edge, 6 cycles after btn_raw rises.
REQ-034 Short press (btn_level high 5 cycles) -> btn_press then btn_release; btn_hold and btn_hold_pulse never assert.
REQ-035 Release timed so it is accepted on the edge the hold counter hits 9 -> btn_release=1, btn_hold_pulse=0, state IDLE.
REQ-036 rst pulsed low while in HELD with btn_raw held low -> outputs 0 at once; after rst=1, btn_press asserts 6 cycles later.
